// File: rtl/act_tile_loader.sv
// ============================================================================
// Module   : act_tile_loader
// Purpose  : Packs a 16-beat int8 activation stream into a 4x4 tile, strobes
//            it into the systolic shift buffer, then holds off for the drain
//            window. Optional macro ACT_LOADER_PREFETCH_EN fills the next tile
//            during the drain window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module act_tile_loader #(
   parameter int SHIFT_CYCLES = 8,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic [7:0]       activation [15:0],
   output logic             load,
   output logic             array_en,
   output logic             tile_done,
   output logic [CNT_W-1:0] tile_count
);

   localparam logic [7:0] c_last_shift = 8'(SHIFT_CYCLES - 1);
   localparam logic [4:0] c_tile_beats = 5'd16;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [4:0]       r_idx;
   logic [4:0]       w_idx_next;
   logic [7:0]       r_cnt;
   logic [7:0]       w_cnt_next;
   logic [7:0]       r_fill [15:0];
   logic [7:0]       w_fill_next [15:0];
   logic [7:0]       r_act [15:0];
   logic             r_load;
   logic             r_array_en;
   logic             r_tile_done;
   logic [CNT_W-1:0] r_tile_count;
   logic             w_accept;
   logic             w_capture;

`ifdef ACT_LOADER_PREFETCH_EN
   // Fill buffer stays open through LOAD/SHIFT until a whole tile is held.
   assign in_ready = (r_idx < c_tile_beats);
`else
   assign in_ready = (r_state == ST_FILL) && (r_idx < c_tile_beats);
`endif

   assign w_accept   = in_valid && in_ready;
   assign w_idx_next = r_idx + {4'd0, w_accept};

   always_comb begin
      w_fill_next = r_fill;
      if (w_accept) begin
         w_fill_next[r_idx[3:0]] = in_data;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_capture    = 1'b0;
      case (r_state)
         ST_FILL: begin
            if (w_idx_next == c_tile_beats) begin
               w_capture    = 1'b1;
               w_state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            w_state_next = ST_SHIFT;
            w_cnt_next   = 8'd0;
         end
         ST_SHIFT: begin
            if (r_cnt == c_last_shift) begin
`ifdef ACT_LOADER_PREFETCH_EN
               if (w_idx_next == c_tile_beats) begin
                  w_capture    = 1'b1;
                  w_state_next = ST_LOAD;
               end else begin
                  w_state_next = ST_FILL;
               end
`else
               w_state_next = ST_FILL;
`endif
            end else begin
               w_cnt_next = r_cnt + 8'd1;
            end
         end
         default: begin
            w_state_next = ST_FILL;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_FILL;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Outputs are registered from the next-state decode so they line up with
   // the state they describe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idx        <= 5'd0;
         r_cnt        <= 8'd0;
         r_load       <= 1'b0;
         r_array_en   <= 1'b0;
         r_tile_done  <= 1'b0;
         r_tile_count <= '0;
         for (int k = 0; k < 16; k++) begin
            r_fill[k] <= 8'd0;
            r_act[k]  <= 8'd0;
         end
      end else begin
         r_idx       <= w_capture ? 5'd0 : w_idx_next;
         r_cnt       <= w_cnt_next;
         r_fill      <= w_fill_next;
         r_load      <= (w_state_next == ST_LOAD);
         r_array_en  <= (w_state_next == ST_LOAD) || (w_state_next == ST_SHIFT);
         r_tile_done <= (w_state_next == ST_SHIFT) && (w_cnt_next == c_last_shift);
         if (w_state_next == ST_LOAD) begin
            r_tile_count <= r_tile_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (w_capture) begin
            r_act <= w_fill_next;
         end
      end
   end

   generate
      for (genvar g = 0; g < 16; g++) begin : g_act
         assign activation[g] = r_act[g];
      end
   endgenerate

   assign load       = r_load;
   assign array_en   = r_array_en;
   assign tile_done  = r_tile_done;
   assign tile_count = r_tile_count;

endmodule

`default_nettype wire

// File: tb/tb_act_tile_loader.sv
// ============================================================================
// Module   : tb_act_tile_loader
// Purpose  : Directed and randomized stimulus for act_tile_loader, checked
//            every cycle against a queue-based tile model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_act_tile_loader;

   localparam int S = 8;

`ifdef ACT_LOADER_PREFETCH_EN
   localparam bit PREFETCH = 1'b1;
`else
   localparam bit PREFETCH = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic [7:0]  activation [15:0];
   logic        load;
   logic        array_en;
   logic        tile_done;
   logic [15:0] tile_count;

   act_tile_loader #(.SHIFT_CYCLES(S), .CNT_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .activation (activation),
      .load       (load),
      .array_en   (array_en),
      .tile_done  (tile_done),
      .tile_count (tile_count)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   string phase = "init";

   // Reference model: pending beats, the presented tile, and the number of
   // cycles since the last load (-1 when no tile is in flight).
   logic [7:0] m_fill [$];
   logic [7:0] m_act [16];
   int         m_since;
   int         m_count;

   function automatic bit exp_ready();
      if (PREFETCH) return (m_fill.size() < 16);
      return (m_since < 0) && (m_fill.size() < 16);
   endfunction

   task automatic model_reset();
      m_fill.delete();
      for (int k = 0; k < 16; k++) m_act[k] = 8'd0;
      m_since = -1;
      m_count = 0;
   endtask

   task automatic model_tick(input bit acc, input logic [7:0] d);
      if (acc) m_fill.push_back(d);
      if (m_since >= 0 && m_since < S) begin
         m_since++;
      end else if (m_fill.size() == 16) begin
         for (int k = 0; k < 16; k++) m_act[k] = m_fill.pop_front();
         m_since = 0;
         m_count++;
      end else begin
         m_since = -1;
      end
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] act_flat();
      logic [127:0] v;
      for (int k = 0; k < 16; k++) v[k*8 +: 8] = activation[k];
      return v;
   endfunction

   task automatic chk_all();
      logic [127:0] e;
      for (int k = 0; k < 16; k++) e[k*8 +: 8] = m_act[k];
      chk({phase, ":in_ready"},   128'(in_ready),   128'(exp_ready()));
      chk({phase, ":load"},       128'(load),       128'(m_since == 0));
      chk({phase, ":array_en"},   128'(array_en),   128'(m_since >= 0 && m_since <= S));
      chk({phase, ":tile_done"},  128'(tile_done),  128'(m_since == S));
      chk({phase, ":tile_count"}, 128'(tile_count), 128'(16'(m_count)));
      chk({phase, ":activation"}, act_flat(),       e);
   endtask

   // Called at a negedge: drive, check, clock the model with the edge.
   task automatic step(input logic v, input logic [7:0] d);
      bit acc;
      in_valid = v;
      in_data  = d;
      #1;
      chk_all();
      acc = v && exp_ready();
      @(posedge clk);
      model_tick(acc, d);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      model_reset();
      #1;
      chk_all();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'(i));
   endtask

   logic [127:0] exp_tile;
   int           sent;

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'd0;
      model_reset();
      @(negedge clk);

      phase = "reset";
      do_reset();

      phase = "seq16";
      for (int k = 0; k < 16; k++) step(1'b1, 8'(k + 1));
      idle(S + 3);
      for (int k = 0; k < 16; k++) exp_tile[k*8 +: 8] = 8'(k + 1);
      chk("seq16:tile", act_flat(), exp_tile);
      chk("seq16:count", 128'(tile_count), 128'd1);

      phase = "toggle";
      sent = 0;
      for (int c = 0; c < 64 && sent < 16; c++) begin
         if (c % 2 == 0) begin
            if (exp_ready()) sent++;
            step(1'b1, 8'(8'h30 + sent));
         end else begin
            step(1'b0, 8'hEE);
         end
      end
      chk("toggle:sent", 128'(sent), 128'd16);
      idle(S + 3);

      phase = "cont48";
      sent = 0;
      for (int c = 0; c < 400 && sent < 48; c++) begin
         if (exp_ready()) sent++;
         step(1'b1, 8'($urandom));
      end
      chk("cont48:sent", 128'(sent), 128'd48);
      idle(2 * S + 20);
      chk("cont48:count", 128'(tile_count), 128'd5);

      phase = "abort10";
      do_reset();
      for (int k = 0; k < 10; k++) step(1'b1, 8'($urandom));
      do_reset();
      for (int k = 0; k < 16; k++) step(1'b1, 8'hA5);
      idle(S + 3);
      chk("abort10:tile", act_flat(), {16{8'hA5}});
      chk("abort10:count", 128'(tile_count), 128'd1);

      phase = "midshift";
      do_reset();
      for (int k = 0; k < 16; k++) step(1'b1, 8'($urandom));
      idle(5);
      do_reset();
      chk("midshift:array_en", 128'(array_en), 128'd0);
      chk("midshift:count", 128'(tile_count), 128'd0);
      idle(S + 3);

      phase = "random";
      for (int c = 0; c < 600; c++) begin
         step(($urandom_range(0, 9) < 7), 8'($urandom));
      end
      idle(S + 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
